// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA/PIM engine: state encoding,
// direction codes and default widths.
package dma_pkg;

    localparam int unsigned XLEN_DEFAULT   = 32;
    localparam int unsigned PIM_AW_DEFAULT = 11;

    localparam logic [2:0] DMA_M2P = 3'b000;
    localparam logic [2:0] DMA_P2M = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MEM_RD = 3'd1,
        ST_PIM_WR = 3'd2,
        ST_PIM_RD = 3'd3,
        ST_MEM_WR = 3'd4,
        ST_DONE   = 3'd5
    } dma_state_e;

endpackage

// File: rtl/dma_pim_engine.sv
// Command-driven DMA engine moving 32-bit words between data memory and one
// of four PIM macros, one word per two cycles while the memory bus is granted.
module dma_pim_engine
    import dma_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned PIM_AW = PIM_AW_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_dma_en,
    input  logic [2:0]        i_dma_funct3,
    input  logic [3:0]        i_dma_sel_pim,
    input  logic [12:0]       i_dma_size,
    input  logic [XLEN-1:0]   i_dma_mem_addr,
    output logic              o_dma_busy,
    output logic              o_dma_done,
    output logic              o_mem_req,
    input  logic              i_mem_gnt,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wr_data,
    output logic [3:0]        o_mem_size,
    output logic              o_mem_read,
    output logic              o_mem_write,
    input  logic [XLEN-1:0]   i_mem_rd_data,
    output logic [3:0]        o_pim_sel,
    output logic [PIM_AW-1:0] o_pim_addr,
    output logic [XLEN-1:0]   o_pim_wr_data,
    output logic              o_pim_read,
    output logic              o_pim_write,
    input  logic [XLEN-1:0]   i_pim_rd_data
);

    dma_state_e        state_q, state_d;
    logic [XLEN-1:0]   base_q;
    logic [PIM_AW-1:0] n_q;
    logic [PIM_AW-1:0] idx_q;
    logic [3:0]        sel_q;
    logic [XLEN-1:0]   hold_q;
    logic              hold_first_q;

    logic [PIM_AW-1:0] cmd_words_c;
    logic              cmd_valid_c;
    logic              last_c;
    logic              unused_bits;

    assign cmd_words_c = PIM_AW'(i_dma_size[12:2]);
    assign cmd_valid_c = (cmd_words_c != '0) &&
                         ((i_dma_funct3 == DMA_M2P) || (i_dma_funct3 == DMA_P2M));
    assign last_c      = (idx_q + PIM_AW'(1)) == n_q;
    assign unused_bits = ^{i_dma_size[1:0], i_dma_mem_addr[1:0]};

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_dma_en) begin
                    if (!cmd_valid_c) begin
                        state_d = ST_DONE;
                    end else if (i_dma_funct3 == DMA_M2P) begin
                        state_d = ST_MEM_RD;
                    end else begin
                        state_d = ST_PIM_RD;
                    end
                end
            end
            ST_MEM_RD: if (i_mem_gnt) state_d = ST_PIM_WR;
            ST_PIM_WR: state_d = last_c ? ST_DONE : ST_MEM_RD;
            ST_PIM_RD: state_d = ST_MEM_WR;
            ST_MEM_WR: if (i_mem_gnt) state_d = last_c ? ST_DONE : ST_PIM_RD;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Strobes and request decode from state and grant
    always_comb begin
        o_dma_busy    = 1'b0;
        o_dma_done    = 1'b0;
        o_mem_req     = 1'b0;
        o_mem_read    = 1'b0;
        o_mem_write   = 1'b0;
        o_mem_size    = 4'h0;
        o_pim_read    = 1'b0;
        o_pim_write   = 1'b0;
        o_pim_wr_data = '0;
        case (state_q)
            ST_MEM_RD: begin
                o_dma_busy = 1'b1;
                o_mem_req  = 1'b1;
                o_mem_read = i_mem_gnt;
                o_mem_size = i_mem_gnt ? 4'hF : 4'h0;
            end
            ST_PIM_WR: begin
                o_dma_busy    = 1'b1;
                o_pim_write   = 1'b1;
                o_pim_wr_data = i_mem_rd_data;
            end
            ST_PIM_RD: begin
                o_dma_busy = 1'b1;
                o_pim_read = 1'b1;
            end
            ST_MEM_WR: begin
                o_dma_busy  = 1'b1;
                o_mem_req   = 1'b1;
                o_mem_write = i_mem_gnt;
                o_mem_size  = i_mem_gnt ? 4'hF : 4'h0;
            end
            ST_DONE: begin
                o_dma_busy = 1'b1;
                o_dma_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Command latch, word index and PIM read-data hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            base_q       <= '0;
            n_q          <= '0;
            idx_q        <= '0;
            sel_q        <= '0;
            hold_q       <= '0;
            hold_first_q <= 1'b0;
        end else begin
            hold_first_q <= (state_q == ST_PIM_RD);
            if (hold_first_q) begin
                hold_q <= i_pim_rd_data;
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_dma_en) begin
                        base_q <= {i_dma_mem_addr[XLEN-1:2], 2'b00};
                        n_q    <= cmd_words_c;
                        idx_q  <= '0;
                        sel_q  <= i_dma_sel_pim;
                    end
                end
                ST_PIM_WR: idx_q <= idx_q + PIM_AW'(1);
                ST_MEM_WR: if (i_mem_gnt) idx_q <= idx_q + PIM_AW'(1);
                default: ;
            endcase
        end
    end

    // PIM read data is live only in the first MEM_WR cycle; afterwards the hold copy is used
    assign o_mem_wr_data = hold_first_q ? i_pim_rd_data : hold_q;
    assign o_mem_addr    = base_q + XLEN'({idx_q, 2'b00});
    assign o_pim_addr    = idx_q;
    assign o_pim_sel     = sel_q;

endmodule

// File: tb/tb_dma_pim_engine.sv
// Self-checking bench for dma_pim_engine: directed table, corner sequences
// and randomized commands against a transfer-list reference model.
module tb_dma_pim_engine;
    import dma_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_dma_en;
    logic [2:0]  i_dma_funct3;
    logic [3:0]  i_dma_sel_pim;
    logic [12:0] i_dma_size;
    logic [31:0] i_dma_mem_addr;
    logic        o_dma_busy, o_dma_done, o_mem_req, i_mem_gnt;
    logic [31:0] o_mem_addr, o_mem_wr_data, i_mem_rd_data;
    logic [3:0]  o_mem_size;
    logic        o_mem_read, o_mem_write;
    logic [3:0]  o_pim_sel;
    logic [10:0] o_pim_addr;
    logic [31:0] o_pim_wr_data, i_pim_rd_data;
    logic        o_pim_read, o_pim_write;

    dma_pim_engine #(.XLEN(32), .PIM_AW(11)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_dma_en(i_dma_en),
        .i_dma_funct3(i_dma_funct3), .i_dma_sel_pim(i_dma_sel_pim),
        .i_dma_size(i_dma_size), .i_dma_mem_addr(i_dma_mem_addr),
        .o_dma_busy(o_dma_busy), .o_dma_done(o_dma_done),
        .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt), .o_mem_addr(o_mem_addr),
        .o_mem_wr_data(o_mem_wr_data), .o_mem_size(o_mem_size),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .i_mem_rd_data(i_mem_rd_data), .o_pim_sel(o_pim_sel),
        .o_pim_addr(o_pim_addr), .o_pim_wr_data(o_pim_wr_data),
        .o_pim_read(o_pim_read), .o_pim_write(o_pim_write),
        .i_pim_rd_data(i_pim_rd_data)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory and PIM macro models
    logic [31:0] pim_mem [4][2048];
    logic [31:0] dmem [logic [31:0]];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (dmem.exists(a)) return dmem[a];
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic int sel_idx(input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) return i;
        return 0;
    endfunction

    // Read data is only valid the cycle after a strobe; otherwise it is noise
    always @(posedge i_clk) begin
        i_mem_rd_data <= o_mem_read ? mem_val(o_mem_addr) : $urandom;
        i_pim_rd_data <= o_pim_read ? pim_mem[sel_idx(o_pim_sel)][o_pim_addr] : $urandom;
    end

    always @(posedge i_clk) begin
        if (o_mem_write) dmem[o_mem_addr] = o_mem_wr_data;
        if (o_pim_write) pim_mem[sel_idx(o_pim_sel)][o_pim_addr] = o_pim_wr_data;
    end

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t q_mrd[$], q_pw[$], q_pr[$], q_mw[$];
    int  busy_cnt, done_cnt, size_err;
    bit  collect = 1'b0;

    always @(negedge i_clk) begin
        if (collect) begin
            if (o_dma_busy) busy_cnt++;
            if (o_dma_done) done_cnt++;
            if (o_mem_read)  q_mrd.push_back('{4'h0, o_mem_addr, 32'h0});
            if (o_pim_write) q_pw.push_back('{o_pim_sel, 32'(o_pim_addr), o_pim_wr_data});
            if (o_pim_read)  q_pr.push_back('{o_pim_sel, 32'(o_pim_addr), 32'h0});
            if (o_mem_write) q_mw.push_back('{4'h0, o_mem_addr, o_mem_wr_data});
            if ((o_mem_read || o_mem_write) && o_mem_size != 4'hF) size_err++;
        end
    end

    function automatic logic any_out();
        return |{o_dma_busy, o_dma_done, o_mem_req, o_mem_addr, o_mem_wr_data,
                 o_mem_size, o_mem_read, o_mem_write, o_pim_sel, o_pim_addr,
                 o_pim_wr_data, o_pim_read, o_pim_write};
    endfunction

    task automatic cmp_q(input string nm, input ev_t got[$], input ev_t exp[$], input bit chk_data);
        check({nm, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            check($sformatf("%s_addr[%0d]", nm, i), 64'({got[i].sel, got[i].addr}),
                  64'({exp[i].sel, exp[i].addr}));
            if (chk_data)
                check($sformatf("%s_data[%0d]", nm, i), 64'(got[i].data), 64'(exp[i].data));
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // Issue one command, run it to completion, compare against the transfer list
    task automatic run_cmd(input string tag, input logic [2:0] f3, input logic [3:0] sel,
                           input logic [12:0] size, input logic [31:0] base, input int inject,
                           input bit gnt_rand, output int busy_o, output int strobes_o,
                           output logic [31:0] first_o);
        int n;
        bit ok, seen;
        logic [31:0] a;
        ev_t e_mrd[$], e_pw[$], e_pr[$], e_mw[$];
        n  = int'(size >> 2);
        ok = ((f3 == DMA_M2P) || (f3 == DMA_P2M)) && (n != 0);
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                a = {base[31:2], 2'b00} + 32'(4 * i);
                if (f3 == DMA_M2P) begin
                    e_mrd.push_back('{4'h0, a, 32'h0});
                    e_pw.push_back('{sel, 32'(i), mem_val(a)});
                end else begin
                    e_pr.push_back('{sel, 32'(i), 32'h0});
                    e_mw.push_back('{4'h0, a, pim_mem[sel_idx(sel)][i]});
                end
            end
        end
        q_mrd.delete(); q_pw.delete(); q_pr.delete(); q_mw.delete();
        busy_cnt = 0; done_cnt = 0; size_err = 0;
        collect = 1'b1;
        i_dma_en = 1'b1; i_dma_funct3 = f3; i_dma_sel_pim = sel;
        i_dma_size = size; i_dma_mem_addr = base;
        i_mem_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10000 && !seen; c++) begin
            cyc();
            i_dma_en       = (c + 1 == inject);
            i_dma_funct3   = 3'($urandom);
            i_dma_sel_pim  = 4'($urandom);
            i_dma_size     = 13'($urandom);
            i_dma_mem_addr = $urandom;
            i_mem_gnt      = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge i_clk);
            if (o_dma_done) seen = 1'b1;
        end
        check({tag, "_finished"}, 64'(seen), 64'(1));
        cyc();
        i_dma_en = 1'b0;
        cyc();
        collect = 1'b0;
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
        if (gnt_rand)
            check({tag, "_busy_min"}, 64'(busy_cnt >= (ok ? 2 * n + 1 : 1)), 64'(1));
        else
            check({tag, "_busy"}, 64'(busy_cnt), 64'(ok ? 2 * n + 1 : 1));
        cmp_q({tag, "_memrd"}, q_mrd, e_mrd, 1'b0);
        cmp_q({tag, "_pimwr"}, q_pw, e_pw, 1'b1);
        cmp_q({tag, "_pimrd"}, q_pr, e_pr, 1'b0);
        cmp_q({tag, "_memwr"}, q_mw, e_mw, 1'b1);
        check({tag, "_mem_size"}, 64'(size_err), 64'(0));
        busy_o    = busy_cnt;
        strobes_o = q_mrd.size() + q_pw.size() + q_pr.size() + q_mw.size();
        first_o   = (q_mrd.size() != 0) ? q_mrd[0].addr :
                    (q_mw.size() != 0) ? q_mw[0].addr : 32'h0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [3:0]  sel;
        logic [12:0] size;
        logic [31:0] base;
        int          inject;
        int          exp_busy;
        int          exp_strobes;
        logic [31:0] exp_first;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int          busy, strobes;
        logic [31:0] first, expd;
        bit          seen, bad;

        vecs[0] = '{3'b000, 4'b0010, 13'd16,     32'h0000_1000, 0, 9,    8,    32'h0000_1000};
        vecs[1] = '{3'b001, 4'b0001, 13'd8,      32'h0000_2002, 0, 5,    4,    32'h0000_2000};
        vecs[2] = '{3'b000, 4'b0100, 13'd3,      32'h0000_1000, 0, 1,    0,    32'h0};
        vecs[3] = '{3'b010, 4'b0010, 13'd16,     32'h0000_1000, 0, 1,    0,    32'h0};
        vecs[4] = '{3'b111, 4'b1000, 13'd8,      32'h0000_5000, 0, 1,    0,    32'h0};
        vecs[5] = '{3'b000, 4'b1000, 13'd8,      32'hFFFF_FFFC, 0, 5,    4,    32'hFFFF_FFFC};
        vecs[6] = '{3'b001, 4'b0100, 13'd12,     32'h0000_3000, 2, 7,    6,    32'h0000_3000};
        vecs[7] = '{3'b000, 4'b0001, 13'd19,     32'h0000_0800, 3, 9,    8,    32'h0000_0800};
        vecs[8] = '{3'b001, 4'b0010, 13'h1FFC,   32'h0000_0010, 0, 4095, 4094, 32'h0000_0010};

        for (int m = 0; m < 4; m++)
            for (int w = 0; w < 2048; w++)
                pim_mem[m][w] = $urandom;

        i_rst_n = 1'b0; i_dma_en = 1'b0; i_dma_funct3 = 3'h0; i_dma_sel_pim = 4'h0;
        i_dma_size = 13'h0; i_dma_mem_addr = 32'h0; i_mem_gnt = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_outputs_zero", 64'(any_out()), 64'(0));
        i_rst_n = 1'b1;
        cyc();

        for (int v = 0; v < 9; v++) begin
            run_cmd($sformatf("vec%0d", v), vecs[v].f3, vecs[v].sel, vecs[v].size,
                    vecs[v].base, vecs[v].inject, 1'b0, busy, strobes, first);
            check($sformatf("vec%0d_tbl_busy", v), 64'(busy), 64'(vecs[v].exp_busy));
            check($sformatf("vec%0d_tbl_strobes", v), 64'(strobes), 64'(vecs[v].exp_strobes));
            check($sformatf("vec%0d_tbl_first", v), 64'(first), 64'(vecs[v].exp_first));
        end

        // Grant withheld for three cycles in MEM_WR
        i_mem_gnt = 1'b0; i_dma_en = 1'b1; i_dma_funct3 = DMA_P2M;
        i_dma_sel_pim = 4'b0100; i_dma_size = 13'd8; i_dma_mem_addr = 32'h0000_4000;
        cyc();
        i_dma_en = 1'b0;
        expd = pim_mem[2][0];
        @(negedge i_clk);
        check("gw_pim_read", 64'({o_pim_read, o_pim_addr}), 64'({1'b1, 11'd0}));
        for (int k = 0; k < 3; k++) begin
            cyc();
            @(negedge i_clk);
            check($sformatf("gw_wait%0d_req_wr", k), 64'({o_mem_req, o_mem_write}), 64'(2'b10));
            check($sformatf("gw_wait%0d_hold", k), 64'(o_mem_wr_data), 64'(expd));
        end
        cyc();
        i_mem_gnt = 1'b1;
        @(negedge i_clk);
        check("gw_write0", 64'({o_mem_write, o_mem_size, o_mem_addr}), 64'({1'b1, 4'hF, 32'h0000_4000}));
        check("gw_write0_data", 64'(o_mem_wr_data), 64'(expd));
        cyc();
        i_mem_gnt = 1'b0;
        expd = pim_mem[2][1];
        @(negedge i_clk);
        check("gw_pim_read1", 64'({o_pim_read, o_pim_addr}), 64'({1'b1, 11'd1}));
        cyc();
        i_mem_gnt = 1'b1;
        @(negedge i_clk);
        check("gw_write1", 64'({o_mem_write, o_mem_addr}), 64'({1'b1, 32'h0000_4004}));
        check("gw_write1_data", 64'(o_mem_wr_data), 64'(expd));
        cyc();
        @(negedge i_clk);
        check("gw_done", 64'({o_dma_done, o_dma_busy}), 64'(2'b11));
        cyc();
        @(negedge i_clk);
        check("gw_idle", 64'({o_dma_done, o_dma_busy}), 64'(2'b00));
        cyc();

        // Reset asserted while a PIM write is in progress
        i_mem_gnt = 1'b1; i_dma_en = 1'b1; i_dma_funct3 = DMA_M2P;
        i_dma_sel_pim = 4'b0010; i_dma_size = 13'd16; i_dma_mem_addr = 32'h0000_1000;
        cyc();
        i_dma_en = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge i_clk);
            if (o_pim_write) seen = 1'b1;
        end
        check("rst_reached_pim_wr", 64'(seen), 64'(1));
        i_rst_n = 1'b0;
        #1;
        check("rst_outputs_zero", 64'(any_out()), 64'(0));
        bad = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge i_clk);
            if (any_out()) bad = 1'b1;
        end
        check("rst_held_zero", 64'(bad), 64'(0));
        i_rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            if (o_dma_busy || o_dma_done) bad = 1'b1;
        end
        check("rst_no_done_no_busy", 64'(bad), 64'(0));
        cyc();

        // Randomized commands with random grant
        for (int t = 0; t < 40; t++) begin
            int unsigned r;
            logic [2:0] f3;
            r  = $urandom_range(0, 99);
            f3 = (r < 45) ? DMA_M2P : (r < 90) ? DMA_P2M : 3'($urandom_range(2, 7));
            run_cmd($sformatf("rnd%0d", t), f3, 4'(1 << $urandom_range(0, 3)),
                    13'($urandom_range(0, 72)), $urandom, int'($urandom_range(0, 6)),
                    1'b1, busy, strobes, first);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
